// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path: address geometry,
// the refill FSM encoding and the helpers that split a pc into line base and word offset.
package icache_pkg;

    localparam int WORD_BYTES = 4;
    localparam int PC_W       = 32;
    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = $clog2(LINE_WORDS);
    localparam int MEM_DEPTH  = 64;
    localparam int INDEX_W    = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        WAIT  = ST_WAIT,
        BURST = ST_BURST
    } state_e;

    // Word index of a byte address with the in-line offset bits cleared.
    function automatic logic [PC_W-1:0] line_base(input logic [PC_W-1:0] addr, input int off_w);
        logic [PC_W-1:0] idx;
        idx = addr >> $clog2(WORD_BYTES);
        return idx & ~((PC_W'(1) << off_w) - PC_W'(1));
    endfunction

    function automatic logic [PC_W-1:0] word_off(input logic [PC_W-1:0] addr, input int off_w);
        logic [PC_W-1:0] idx;
        idx = addr >> $clog2(WORD_BYTES);
        return idx & ((PC_W'(1) << off_w) - PC_W'(1));
    endfunction

endpackage

// File: rtl/imem_array.sv
// Word-addressed backing store: one synchronous write port, one registered read port,
// read-before-write when both hit the same word on the same edge.
module imem_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto RAM and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_refill_responder.sv
// Memory side of the I-cache refill: accepts one miss, waits LATENCY cycles, then streams
// the line critical-word-first, wrapping within the line.
module imem_refill_responder
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_WORDS      = 64,
    parameter int LATENCY        = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    input  logic [ADDR_W-1:0]                 req_addr,
    output logic                              req_ready,
    output logic                              rsp_valid,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] rsp_word,
    output logic                              rsp_last,
    output logic                              rsp_err,
    output logic                              busy,
    input  logic                              ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0]      ld_addr,
    input  logic [DATA_W-1:0]                 ld_data
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);
    localparam logic [OFF_W:0]   NUM_BEATS = (OFF_W + 1)'(WORDS_PER_LINE);
    localparam logic [OFF_W:0]   LAST_BEAT = (OFF_W + 1)'(WORDS_PER_LINE - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OFF_W:0]     beat_q;
    logic [IDX_W-1:0]   line_q;
    logic [OFF_W-1:0]   start_q;
    logic               err_q;
    logic               req_ready_q;
    logic               busy_q;
    logic               rsp_valid_q;
    logic [OFF_W-1:0]   rsp_word_q;
    logic               rsp_last_q;
    logic               rsp_err_q;

    logic [PC_W-1:0]    pc_d;
    logic [IDX_W-1:0]   line_d;
    logic [OFF_W-1:0]   start_d;
    logic               err_d;
    logic               issue_d;
    logic [OFF_W-1:0]   rd_off_d;
    logic [IDX_W-1:0]   rd_addr_d;
    logic [DATA_W-1:0]  ram_rd_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d      = PC_W'(req_addr);
        line_d    = IDX_W'(line_base(pc_d, OFF_W));
        start_d   = OFF_W'(word_off(pc_d, OFF_W));
        err_d     = (req_addr >> $clog2(WORD_BYTES)) >= ADDR_W'(MEM_WORDS);
        issue_d   = 1'b0;
        rd_off_d  = start_q + beat_q[OFF_W-1:0];
        rd_addr_d = line_q | IDX_W'(rd_off_d);
        if (state_q == WAIT && cnt_q == '0) begin
            issue_d = 1'b1;
        end else if (state_q == BURST && beat_q != NUM_BEATS) begin
            issue_d = 1'b1;
        end
    end

    // A beat is read from the array on the edge it is issued, so data and sideband
    // registers line up on the same cycle.
    imem_array #(
        .DEPTH  (MEM_WORDS),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (ld_en),
        .wr_addr_i (ld_addr),
        .wr_data_i (ld_data),
        .rd_en_i   (issue_d),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (ram_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            start_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_word_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        line_q      <= line_d;
                        start_q     <= start_d;
                        err_q       <= err_d;
                        cnt_q       <= CNT_INIT;
                        beat_q      <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= BURST;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BURST: begin
                    // All beats issued: this is the rsp_last cycle, re-arm on the next edge.
                    if (!issue_d) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        rsp_valid_q <= 1'b0;
                        rsp_word_q  <= '0;
                        rsp_last_q  <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (issue_d) begin
                beat_q      <= beat_q + 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_word_q  <= rd_off_d;
                rsp_last_q  <= (beat_q == LAST_BEAT);
                rsp_err_q   <= err_q;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_word  = rsp_word_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = (rsp_valid_q && !rsp_err_q) ? ram_rd_data : '0;

endmodule

// File: tb/tb_imem_refill_responder.sv
// Scoreboard bench: accepted requests push their expected beats, a negedge monitor
// pops and compares against a word-level memory model.
module tb_imem_refill_responder;

    localparam int LAT = 6;
    localparam int WPL = 4;
    localparam int MW  = 64;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_word;
    logic        rsp_last;
    logic        rsp_err;
    logic        busy;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;

    imem_refill_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_word  (rsp_word),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int word;
        int idx;
        bit err;
        bit last;
        int cyc;
    } beat_t;

    beat_t       sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_edge = -1000;
    logic [31:0] mem_model [MW];
    int          last_wr_cyc = -1;
    int          last_wr_addr = 0;
    logic [31:0] last_wr_old = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {req_ready, rsp_valid, rsp_last, rsp_err, busy, rsp_word, rsp_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0});
    endtask

    // Reference: an accepted request at edge a yields WPL beats, beat b on edge a+LAT+b.
    task automatic push_burst(input logic [31:0] addr, input int a);
        int w;
        beat_t e;
        w = int'(addr >> 2);
        acc_edge = a;
        for (int b = 0; b < WPL; b++) begin
            e.err  = (addr >> 2) >= 32'(MW);
            e.word = ((w % WPL) + b) % WPL;
            e.idx  = e.err ? 0 : (w - (w % WPL)) + e.word;
            e.last = (b == WPL - 1);
            e.cyc  = a + LAT + b;
            sb_q.push_back(e);
        end
    endtask

    // Model memory follows the real write port; the previous value of the word written on
    // the latest edge is kept so same-edge reads can expect the old data.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) begin
            mem_model[ld_addr] <= ld_data;
            last_wr_cyc        <= cyc + 1;
            last_wr_addr       <= int'(ld_addr);
            last_wr_old        <= mem_model[ld_addr];
        end
    end

    beat_t       mb;
    logic [31:0] exp_data;
    bit          exp_busy;

    always @(negedge clk) begin
        if (!rst) begin
            exp_busy = (cyc >= acc_edge) && (cyc <= acc_edge + LAT + WPL - 1);
            check("busy", busy, exp_busy);
            check("req_ready", req_ready, !exp_busy);
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_beat", rsp_valid, 1'b0);
                end else begin
                    mb = sb_q.pop_front();
                    if (mb.err)
                        exp_data = '0;
                    else if (last_wr_cyc == cyc && last_wr_addr == mb.idx)
                        exp_data = last_wr_old;
                    else
                        exp_data = mem_model[mb.idx];
                    check("beat_cycle", cyc, mb.cyc);
                    check("rsp_word", rsp_word, mb.word);
                    check("rsp_last", rsp_last, mb.last);
                    check("rsp_err", rsp_err, mb.err);
                    check("rsp_data", rsp_data, exp_data);
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
                mb = sb_q.pop_front();
                check("missing_beat", rsp_valid, 1'b1);
            end
        end
    end

    task automatic drive_cycle(input logic v, input logic [31:0] a, input logic le,
                               input logic [5:0] la, input logic [31:0] ld);
        @(posedge clk);
        #2;
        req_valid = v;
        req_addr  = a;
        ld_en     = le;
        ld_addr   = la;
        ld_data   = ld;
        if (v && req_ready) push_burst(a, cyc + 1);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, req_addr, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) idle_cycle();
    endtask

    task automatic do_req(input logic [31:0] a);
        int n;
        n = 0;
        while (!req_ready && n < 60) begin
            idle_cycle();
            n++;
        end
        if (!req_ready) check("req_ready_timeout", req_ready, 1'b1);
        drive_cycle(1'b1, a, 1'b0, 6'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", sb_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #3;
        check_reset_outputs("reset_values");
        @(posedge clk); #2;
        rst = 1'b0;

        for (int i = 0; i < MW; i++) drive_cycle(1'b0, 32'h0, 1'b1, 6'(i), 32'hA000_0000 + 32'(i));
        idle_cycle();

        do_req(32'h0000_0000);
        do_req(32'h0000_001C);

        do_req(32'h0000_0054);
        repeat (3) drive_cycle(1'b1, 32'h0000_0024, 1'b0, 6'd0, 32'h0);
        idle_cycle();

        do_req(32'h0000_0100);

        // Preload during WAIT, then a write landing on the same edge the word is read.
        do_req(32'h0000_0020);
        a0 = acc_edge;
        wait_to(a0 + 1);
        drive_cycle(1'b0, req_addr, 1'b1, 6'd10, 32'hDEAD_BEEF);
        wait_to(a0 + 7);
        drive_cycle(1'b0, req_addr, 1'b1, 6'd11, 32'h1111_1111);
        idle_cycle();
        do_req(32'h0000_002C);

        // Abort on the second beat; memory must survive the reset.
        do_req(32'h0000_0030);
        a0 = acc_edge;
        wait_to(a0 + LAT + 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_burst");
        sb_q.delete();
        acc_edge = -1000;
        @(posedge clk); #2;
        rst = 1'b0;
        do_req(32'h0000_0008);

        for (int i = 0; i < 1200; i++) begin
            drive_cycle($urandom_range(0, 3) == 0,
                        ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                        $urandom_range(0, 3) == 0, 6'($urandom_range(0, MW - 1)), $urandom);
        end
        idle_cycle();
        wait_to(cyc + LAT + WPL + 4);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
